// File: rtl/cla_nibble_subtractor_if.sv
// Start/done handshake bundle for the nibble-serial CLA subtractor.
// The sequencer drives through the master modport and the datapath through the slave modport.
interface cla_nibble_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             overflow;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow, overflow
   );
endinterface

// File: rtl/cla_nibble_subtractor.sv
// Multi-cycle subtractor: diff = a - b, one 4-bit carry-lookahead slice per clock, LSB nibble first.
// Subtraction is a + ~b + 1, with the +1 entering as the initial value of the carry register.
module cla_nibble_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   cla_nibble_subtractor_if.slave  sub
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] diff_r;
   logic [IDXW-1:0]  idx;
   logic             carry;
   logic             busy_r;
   logic             done_r;
   logic             borrow_r;
   logic             ovf_r;

   logic [3:0]       x;
   logic [3:0]       y;
   logic [3:0]       p;
   logic [3:0]       g;
   logic [4:0]       c;
   logic [3:0]       s;

   // Lookahead slice on the current nibble; all four carries come straight from P/G and the carry-in.
   always_comb begin
      x    = 4'(a_r >> {idx, 2'b00});
      y    = ~4'(b_r >> {idx, 2'b00});
      p    = x ^ y;
      g    = x & y;
      c[0] = carry;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      s    = p ^ c[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_r      <= '0;
         b_r      <= '0;
         diff_r   <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         borrow_r <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (sub.start) begin
                  a_r      <= sub.a;
                  b_r      <= sub.b;
                  carry    <= 1'b1;
                  idx      <= '0;
                  diff_r   <= '0;
                  borrow_r <= 1'b0;
                  ovf_r    <= 1'b0;
                  busy_r   <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               for (int k = 0; k < NIB; k++) begin
                  if (idx == IDXW'(k)) diff_r[4*k +: 4] <= s;
               end
               carry <= c[4];
               // Flags are only meaningful for the top nibble, so they are captured just once.
               if (idx == LAST) begin
                  borrow_r <= ~c[4];
                  ovf_r    <= c[3] ^ c[4];
                  done_r   <= 1'b1;
                  idx      <= '0;
                  state    <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign sub.busy     = busy_r;
   assign sub.done     = done_r;
   assign sub.diff     = diff_r;
   assign sub.borrow   = borrow_r;
   assign sub.overflow = ovf_r;

endmodule

// File: tb/tb_cla_nibble_subtractor.sv
// Directed bench for cla_nibble_subtractor: vector table plus hand-written handshake sequences.
module tb_cla_nibble_subtractor;

   localparam int WIDTH = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cla_nibble_subtractor_if #(.WIDTH(WIDTH)) bif ();

   cla_nibble_subtractor #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .sub (bif)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] diff;
      logic        borrow;
      logic        overflow;
   } vec_t;

   vec_t vecs[9];
   int   total = 0;
   int   bad   = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Issue one start and wait (bounded) for done; inputs are scrambled after acceptance.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                output int lat, output int busyCycles);
      @(negedge clk);
      bif.start = 1'b1;
      bif.a     = a;
      bif.b     = b;
      @(posedge clk);
      lat        = 0;
      busyCycles = 0;
      @(negedge clk);
      bif.start = 1'b0;
      bif.a     = ~a;
      bif.b     = ~b;
      for (int k = 0; k < 20; k++) begin
         if (bif.busy) busyCycles++;
         if (bif.done) break;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   initial begin
      int lat;
      int busyCycles;
      int doneCount;
      int prevDone;
      logic [15:0] expDiff;

      vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
      vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
      vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
      vecs[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
      vecs[5] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
      vecs[6] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0};
      vecs[7] = '{16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1};
      vecs[8] = '{16'hABCD, 16'h1234, 16'h9999, 1'b0, 1'b0};

      rst       = 1'b1;
      bif.start = 1'b0;
      bif.a     = '0;
      bif.b     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy", bif.busy, 0);
      checkOutput("reset_done", bif.done, 0);
      checkOutput("reset_diff", bif.diff, 0);
      checkOutput("reset_borrow", bif.borrow, 0);
      checkOutput("reset_overflow", bif.overflow, 0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, lat, busyCycles);
         checkOutput($sformatf("vec%0d_latency", i), lat, 4);
         checkOutput($sformatf("vec%0d_busy_cycles", i), busyCycles, 5);
         checkOutput($sformatf("vec%0d_diff", i), bif.diff, vecs[i].diff);
         checkOutput($sformatf("vec%0d_borrow", i), bif.borrow, vecs[i].borrow);
         checkOutput($sformatf("vec%0d_overflow", i), bif.overflow, vecs[i].overflow);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_done_one_cycle", i), bif.done, 0);
         checkOutput($sformatf("vec%0d_busy_after", i), bif.busy, 0);
         checkOutput($sformatf("vec%0d_diff_held", i), bif.diff, vecs[i].diff);
      end

      // start pulsed during RUN with new operands must be ignored
      @(negedge clk);
      bif.start = 1'b1;
      bif.a     = 16'h0005;
      bif.b     = 16'h0003;
      @(posedge clk);
      @(negedge clk);
      bif.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bif.start = 1'b1;
      bif.a     = 16'hFFFF;
      bif.b     = 16'h0001;
      @(posedge clk);
      @(negedge clk);
      bif.start = 1'b0;
      bif.a     = 16'h1234;
      bif.b     = 16'h4321;
      for (int k = 0; k < 20; k++) begin
         if (bif.done) break;
         @(negedge clk);
      end
      checkOutput("busy_start_done_seen", bif.done, 1);
      checkOutput("busy_start_diff", bif.diff, 16'h0002);
      checkOutput("busy_start_borrow", bif.borrow, 0);
      busyCycles = 0;
      repeat (8) begin
         @(negedge clk);
         if (bif.busy) busyCycles++;
      end
      checkOutput("busy_start_no_second_op", busyCycles, 0);

      // reset after two RUN edges aborts the operation
      @(negedge clk);
      bif.start = 1'b1;
      bif.a     = 16'h5555;
      bif.b     = 16'h1111;
      @(posedge clk);
      @(negedge clk);
      bif.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("partial_diff", bif.diff, 16'h0044);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_busy", bif.busy, 0);
      checkOutput("abort_done", bif.done, 0);
      checkOutput("abort_diff", bif.diff, 0);
      checkOutput("abort_borrow", bif.borrow, 0);
      checkOutput("abort_overflow", bif.overflow, 0);
      rst       = 1'b0;
      doneCount = 0;
      repeat (8) begin
         @(negedge clk);
         if (bif.done) doneCount++;
      end
      checkOutput("abort_no_done", doneCount, 0);
      applyStimulus(16'hFFFF, 16'hFFFF, lat, busyCycles);
      checkOutput("post_abort_latency", lat, 4);
      checkOutput("post_abort_diff", bif.diff, 16'h0000);
      checkOutput("post_abort_borrow", bif.borrow, 0);
      checkOutput("post_abort_overflow", bif.overflow, 0);

      // start held high: back-to-back operations six edges apart
      @(negedge clk);
      bif.start = 1'b1;
      bif.a     = 16'h0010;
      bif.b     = 16'h0001;
      expDiff   = 16'h000F;
      doneCount = 0;
      prevDone  = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bif.done) begin
            checkOutput($sformatf("held_diff_%0d", doneCount), bif.diff, expDiff);
            if (doneCount == 0) checkOutput("held_first_done_cycle", c, 5);
            else checkOutput($sformatf("held_spacing_%0d", doneCount), c - prevDone, 6);
            prevDone = c;
            doneCount++;
         end
      end
      checkOutput("held_done_count", doneCount, 3);
      bif.start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (!bif.busy) break;
         @(negedge clk);
      end
      checkOutput("held_drain_idle", bif.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
